// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// State encoding, owner codes and wait-counter sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_DSP_ACC = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DSP  = 2'b10;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = 15;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker for the memory arbiter.
// MEM_ARB_RR_EN defined: round-robin on ties; undefined: CPU has fixed priority.
module mem_arb_pick (
    input  logic cpu_req,
    input  logic dsp_req,
    input  logic last_grant,   // 1 = display was granted last
    output logic grant_cpu,
    output logic grant_dsp
);

`ifdef MEM_ARB_RR_EN
    // On a tie the port that did not win last time is served.
    assign grant_cpu = cpu_req & (~dsp_req | last_grant);
    assign grant_dsp = dsp_req & (~cpu_req | ~last_grant);
`else
    logic unused_last_grant;

    assign unused_last_grant = last_grant;
    assign grant_cpu         = cpu_req;
    assign grant_dsp         = dsp_req & ~cpu_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one combinational RAM between the CPU port and a read-only display port.
// Tie-break policy selected by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dsp_req,
    input  logic [ADDR_W-1:0] dsp_addr,
    output logic [DATA_W-1:0] dsp_rdata,
    output logic              dsp_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        owner
);

    localparam logic [CNT_W-1:0] WAIT_INIT   = CNT_W'(WAIT_CYCLES);
    localparam logic             WE_AT_GRANT = (WAIT_CYCLES == 0);

    generate
        if (WAIT_CYCLES > CNT_MAX) begin : g_bad_wait
            $error("mem_port_arbiter: WAIT_CYCLES exceeds the 4-bit wait counter");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             acc_we;
    logic             last_grant;
    logic             grant_cpu;
    logic             grant_dsp;

    mem_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dsp_req    (dsp_req),
        .last_grant (last_grant),
        .grant_cpu  (grant_cpu),
        .grant_dsp  (grant_dsp)
    );

    // ram_we is registered one cycle ahead so it is high exactly while the counter reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            acc_we     <= 1'b0;
            last_grant <= 1'b1;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            cpu_rdata  <= '0;
            dsp_rdata  <= '0;
            cpu_ack    <= 1'b0;
            dsp_ack    <= 1'b0;
            owner      <= OWN_NONE;
        end else begin
            cpu_ack <= 1'b0;
            dsp_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_cpu) begin
                        ram_addr   <= cpu_addr;
                        ram_wdata  <= cpu_wdata;
                        acc_we     <= cpu_we;
                        ram_we     <= cpu_we & WE_AT_GRANT;
                        wait_cnt   <= WAIT_INIT;
                        owner      <= OWN_CPU;
                        last_grant <= 1'b0;
                        state      <= ST_CPU_ACC;
                    end else if (grant_dsp) begin
                        ram_addr   <= dsp_addr;
                        acc_we     <= 1'b0;
                        ram_we     <= 1'b0;
                        wait_cnt   <= WAIT_INIT;
                        owner      <= OWN_DSP;
                        last_grant <= 1'b1;
                        state      <= ST_DSP_ACC;
                    end
                end
                ST_CPU_ACC, ST_DSP_ACC: begin
                    if (wait_cnt == '0) begin
                        ram_we <= 1'b0;
                        owner  <= OWN_NONE;
                        state  <= ST_DONE;
                        if (state == ST_CPU_ACC) begin
                            cpu_ack <= 1'b1;
                            if (!acc_we) begin
                                cpu_rdata <= ram_rdata;
                            end
                        end else begin
                            dsp_ack   <= 1'b1;
                            dsp_rdata <= ram_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                        ram_we   <= acc_we & (wait_cnt == CNT_W'(1));
                    end
                end
                ST_DONE: begin
                    ram_we <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    ram_we <= 1'b0;
                    owner  <= OWN_NONE;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main instance WAIT_CYCLES=1, plus WAIT_CYCLES=0 and 3 instances.
// Each instance has its own behavioural combinational RAM.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    logic rst_bc;

    int n_cmp;
    int n_err;

    // main DUT (WAIT_CYCLES = 1)
    logic        cpu_req, cpu_we, dsp_req;
    logic [15:0] cpu_addr, dsp_addr, ram_addr;
    logic [31:0] cpu_wdata, cpu_rdata, dsp_rdata, ram_wdata, ram_rdata;
    logic        cpu_ack, dsp_ack, ram_we;
    logic [1:0]  owner;
    logic [31:0] mem_a [0:65535];

    // WAIT_CYCLES = 0 instance
    logic        dsp_req_b, cpu_ack_b, dsp_ack_b, ram_we_b;
    logic [15:0] ram_addr_b;
    logic [31:0] cpu_rdata_b, dsp_rdata_b, ram_wdata_b, ram_rdata_b;
    logic [1:0]  owner_b;
    logic [31:0] mem_b [0:65535];

    // WAIT_CYCLES = 3 instance
    logic        dsp_req_c, cpu_ack_c, dsp_ack_c, ram_we_c;
    logic [15:0] ram_addr_c;
    logic [31:0] cpu_rdata_c, dsp_rdata_c, ram_wdata_c, ram_rdata_c;
    logic [1:0]  owner_c;
    logic [31:0] mem_c [0:65535];

    int cpu_ack_cnt, dsp_ack_cnt, we_cnt;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_rdata(dsp_rdata), .dsp_ack(dsp_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .owner(owner)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(rst_bc),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(16'h0000), .cpu_wdata(32'h0),
        .cpu_rdata(cpu_rdata_b), .cpu_ack(cpu_ack_b),
        .dsp_req(dsp_req_b), .dsp_addr(16'h0040), .dsp_rdata(dsp_rdata_b), .dsp_ack(dsp_ack_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_we(ram_we_b), .ram_rdata(ram_rdata_b),
        .owner(owner_b)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .reset(rst_bc),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(16'h0000), .cpu_wdata(32'h0),
        .cpu_rdata(cpu_rdata_c), .cpu_ack(cpu_ack_c),
        .dsp_req(dsp_req_c), .dsp_addr(16'h0040), .dsp_rdata(dsp_rdata_c), .dsp_ack(dsp_ack_c),
        .ram_addr(ram_addr_c), .ram_wdata(ram_wdata_c), .ram_we(ram_we_c), .ram_rdata(ram_rdata_c),
        .owner(owner_c)
    );

    assign ram_rdata   = mem_a[ram_addr];
    assign ram_rdata_b = mem_b[ram_addr_b];
    assign ram_rdata_c = mem_c[ram_addr_c];

    always @(posedge clk) begin
        if (ram_we)   mem_a[ram_addr]   <= ram_wdata;
        if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
        if (ram_we_c) mem_c[ram_addr_c] <= ram_wdata_c;
    end

    always @(negedge clk) begin
        if (cpu_ack) cpu_ack_cnt <= cpu_ack_cnt + 1;
        if (dsp_ack) dsp_ack_cnt <= dsp_ack_cnt + 1;
        if (ram_we)  we_cnt      <= we_cnt + 1;
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU access on the main DUT; lat = edges from grant edge to ack visible.
    task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                          output int lat);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        tick();
        lat = 0;
        while (!cpu_ack && lat < 20) begin
            tick();
            lat++;
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();
    endtask

    int lat;
    int n_acks;
    int seq [0:5];
    int base_cpu, base_dsp, base_we;

    initial begin
        clk = 1'b0; reset = 1'b1; rst_bc = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dsp_req = 1'b0; dsp_addr = '0;
        dsp_req_b = 1'b0; dsp_req_c = 1'b0;
        n_cmp = 0; n_err = 0;
        cpu_ack_cnt = 0; dsp_ack_cnt = 0; we_cnt = 0;
        mem_a[16'h0010] = 32'hDEADBEEF;
        mem_a[16'h0020] = 32'h00000000;
        mem_a[16'h0030] = 32'hAAAA5555;
        mem_a[16'h0040] = 32'h77778888;
        mem_a[16'h0050] = 32'h5A5A5A5A;
        mem_b[16'h0040] = 32'hCAFEF00D;
        mem_c[16'h0040] = 32'h0BADF00D;
        tick(); tick();

        // reset state
        check("rst_cpu_ack",   32'(cpu_ack),   32'd0);
        check("rst_dsp_ack",   32'(dsp_ack),   32'd0);
        check("rst_ram_we",    32'(ram_we),    32'd0);
        check("rst_ram_addr",  32'(ram_addr),  32'd0);
        check("rst_ram_wdata", ram_wdata,      32'd0);
        check("rst_cpu_rdata", cpu_rdata,      32'd0);
        check("rst_dsp_rdata", dsp_rdata,      32'd0);
        check("rst_owner",     32'(owner),     32'd0);
        reset = 1'b0; rst_bc = 1'b0;
        tick();

        // 1: CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        tick();
        check("t1_ram_addr", 32'(ram_addr), 32'h0010);
        check("t1_owner",    32'(owner),    32'd1);
        lat = 0;
        while (!cpu_ack && lat < 20) begin
            tick();
            lat++;
        end
        check("t1_latency", 32'(lat), 32'd2);
        check("t1_rdata",   cpu_rdata, 32'hDEADBEEF);
        check("t1_owner_done", 32'(owner), 32'd0);
        cpu_req = 1'b0;
        tick();
        check("t1_no_dsp_ack", 32'(dsp_ack_cnt), 32'd0);

        // 2: CPU write, ram_we exactly in the middle cycle
        base_we = we_cnt;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 32'h12345678;
        tick();
        check("t2_we_grant", 32'(ram_we), 32'd0);
        tick();
        check("t2_we_pulse", 32'(ram_we), 32'd1);
        check("t2_ack_early", 32'(cpu_ack), 32'd0);
        tick();
        check("t2_we_done", 32'(ram_we), 32'd0);
        check("t2_ack",     32'(cpu_ack), 32'd1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        check("t2_we_count", 32'(we_cnt - base_we), 32'd1);
        check("t2_mem",      mem_a[16'h0020], 32'h12345678);
        cpu_op(1'b0, 16'h0020, 32'h0, lat);
        check("t2_readback", cpu_rdata, 32'h12345678);

        // 5: display reads at WAIT_CYCLES 0 and 3
        dsp_req_b = 1'b1;
        tick();
        lat = 0;
        while (!dsp_ack_b && lat < 20) begin
            tick();
            lat++;
        end
        dsp_req_b = 1'b0;
        check("t5_w0_latency", 32'(lat), 32'd1);
        check("t5_w0_rdata",   dsp_rdata_b, 32'hCAFEF00D);
        dsp_req_c = 1'b1;
        tick();
        lat = 0;
        while (!dsp_ack_c && lat < 20) begin
            tick();
            lat++;
        end
        dsp_req_c = 1'b0;
        check("t5_w3_latency", 32'(lat), 32'd4);
        check("t5_w3_rdata",   dsp_rdata_c, 32'h0BADF00D);
        check("t5_cpu_idle_b", {31'(cpu_rdata_b), cpu_ack_b}, 32'd0);
        check("t5_cpu_idle_c", {31'(cpu_rdata_c), cpu_ack_c}, 32'd0);
        check("t5_no_we", {28'(0), ram_we_b, ram_we_c, owner_b[0], owner_c[1]}, 32'd0);

        // 3: both ports requesting continuously, starting from reset
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        dsp_req = 1'b1; dsp_addr = 16'h0040;
        n_acks = 0;
        for (int i = 0; i < 60 && n_acks < 6; i++) begin
            tick();
            if (cpu_ack) begin
                seq[n_acks] = 0;
                n_acks++;
            end else if (dsp_ack) begin
                seq[n_acks] = 1;
                n_acks++;
            end
        end
        cpu_req = 1'b0; dsp_req = 1'b0;
        check("t3_grants", 32'(n_acks), 32'd6);
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
            check($sformatf("t3_order%0d", k), 32'(seq[k]), 32'(k % 2));
`else
            check($sformatf("t3_order%0d", k), 32'(seq[k]), 32'd0);
`endif
        end
`ifdef MEM_ARB_RR_EN
        check("t3_dsp_rdata", dsp_rdata, 32'h77778888);
`else
        check("t3_dsp_rdata", dsp_rdata, 32'h00000000);
`endif
        tick(); tick(); tick();

        // 4: reset while a CPU write is in its access phase
        base_cpu = cpu_ack_cnt; base_we = we_cnt;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 32'h11111111;
        tick();
        check("t4_owner_grant", 32'(owner), 32'd1);
        reset = 1'b1;
        tick();
        check("t4_we",    32'(ram_we),  32'd0);
        check("t4_ack",   32'(cpu_ack), 32'd0);
        check("t4_owner", 32'(owner),   32'd0);
        tick();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        tick(); tick(); tick(); tick();
        check("t4_mem",       mem_a[16'h0030], 32'hAAAA5555);
        check("t4_we_count",  32'(we_cnt - base_we), 32'd0);
        check("t4_ack_count", 32'(cpu_ack_cnt - base_cpu), 32'd0);

        // 6: request dropped right after grant
        base_cpu = cpu_ack_cnt; base_dsp = dsp_ack_cnt; base_we = we_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050;
        tick();
        cpu_req = 1'b0; cpu_addr = 16'h0010;
        lat = 0;
        while (!cpu_ack && lat < 20) begin
            tick();
            lat++;
        end
        check("t6_latency", 32'(lat), 32'd2);
        check("t6_rdata",   cpu_rdata, 32'h5A5A5A5A);
        for (int i = 0; i < 6; i++) tick();
        check("t6_ack_count", 32'(cpu_ack_cnt - base_cpu), 32'd1);
        check("t6_dsp_count", 32'(dsp_ack_cnt - base_dsp), 32'd0);
        check("t6_we_count",  32'(we_cnt - base_we), 32'd0);
        check("t6_owner",     32'(owner), 32'd0);
        check("t6_rdata_held", cpu_rdata, 32'h5A5A5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
